// File: rtl/pulse_seq_gen.sv
// NCH-channel programmable pulse sequencer sharing one repetition period.
// Timing registers are shadowed and only applied at period boundaries, so running trains never glitch.
module pulse_seq_gen #(
  parameter int NCH           = 4,
  parameter int CW            = 32,
  parameter int SYNC_W        = 4,
  parameter int DEF_PERIOD    = 1000,
  parameter int DEF_DELAY     = 200,
  parameter int DEF_WIDTH     = 30,
  parameter int DEF_SPACE     = 400,
  parameter int DEF_REPS      = 1,
  parameter int DEF_BLOCK_OFF = 100,
  parameter int DEF_EN        = 1,
  parameter int AW            = $clog2(4 + 4 * NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [CW-1:0]  wr_data,
  output logic [NCH-1:0] ch_out,
  output logic           sync,
  output logic           inhib,
  output logic           period_done,
  output logic           busy
);

  typedef enum logic [1:0] {ST_WAIT, ST_ON, ST_GAP, ST_DONE} ch_state_e;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  endfunction

  logic [CW-1:0] per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [CW-1:0] blk_sh_q, blk_sh_d, blk_act_q, blk_act_d;
  logic [NCH-1:0][CW-1:0] dly_sh_q, dly_sh_d, dly_act_q, dly_act_d;
  logic [NCH-1:0][CW-1:0] wid_sh_q, wid_sh_d, wid_act_q, wid_act_d;
  logic [NCH-1:0][CW-1:0] spc_sh_q, spc_sh_d, spc_act_q, spc_act_d;
  logic [NCH-1:0][CW-1:0] rep_sh_q, rep_sh_d, rep_act_q, rep_act_d;

  logic          en_q, en_d, ss_q, ss_d, run_q, run_d;
  logic [CW-1:0] t_q, t_d, tail_q, tail_d;
  logic [CW-1:0] per_eff_q, per_eff_d;
  logic          ctrl_wr, wrap, start_period, copy_en, any_active;

  ch_state_e     st_q [NCH];
  ch_state_e     st_d [NCH];
  logic [CW-1:0] start_q [NCH];
  logic [CW-1:0] start_d [NCH];
  logic [CW-1:0] k_q [NCH];
  logic [CW-1:0] k_d [NCH];
  logic [CW-1:0] nxt_start [NCH];
  logic [CW-1:0] pulse_end [NCH];

  logic [NCH-1:0] ch_out_q, ch_out_d;
  logic           sync_q, sync_d, inhib_q, inhib_d, pdone_q, pdone_d, busy_q, busy_d;

  assign per_eff_q = (per_act_q < CW'(2)) ? CW'(2) : per_act_q;
  assign wrap      = run_q && (t_q == per_eff_q - CW'(1));
  assign ctrl_wr   = wr_en && (wr_addr == AW'(2));

  always_comb begin
    per_sh_d = per_sh_q;
    blk_sh_d = blk_sh_q;
    dly_sh_d = dly_sh_q;
    wid_sh_d = wid_sh_q;
    spc_sh_d = spc_sh_q;
    rep_sh_d = rep_sh_q;
    en_d     = en_q;
    ss_d     = ss_q;
    if (wr_en) begin
      if (wr_addr == AW'(0)) per_sh_d = wr_data;
      if (wr_addr == AW'(1)) blk_sh_d = wr_data;
      for (int i = 0; i < NCH; i++) begin
        if (wr_addr == AW'(4 + 4 * i)) dly_sh_d[i] = wr_data;
        if (wr_addr == AW'(5 + 4 * i)) wid_sh_d[i] = wr_data;
        if (wr_addr == AW'(6 + 4 * i)) spc_sh_d[i] = wr_data;
        if (wr_addr == AW'(7 + 4 * i)) rep_sh_d[i] = wr_data;
      end
    end
    // An explicit control write wins over the single-shot auto-clear.
    if (ctrl_wr) begin
      en_d = wr_data[0];
      ss_d = wr_data[1];
    end else if (wrap && ss_q) begin
      en_d = 1'b0;
    end
  end

  always_comb begin
    run_d        = 1'b0;
    t_d          = '0;
    start_period = 1'b0;
    if (en_d) begin
      run_d = 1'b1;
      if (!run_q || wrap) start_period = 1'b1;
      else                t_d = t_q + CW'(1);
    end
  end

  assign copy_en   = wrap || !run_q;
  assign per_act_d = copy_en ? per_sh_d : per_act_q;
  assign blk_act_d = copy_en ? blk_sh_d : blk_act_q;
  assign dly_act_d = copy_en ? dly_sh_d : dly_act_q;
  assign wid_act_d = copy_en ? wid_sh_d : wid_act_q;
  assign spc_act_d = copy_en ? spc_sh_d : spc_act_q;
  assign rep_act_d = copy_en ? rep_sh_d : rep_act_q;
  assign per_eff_d = (per_act_d < CW'(2)) ? CW'(2) : per_act_d;

  // Each channel tracks the start of its current pulse; the next state is evaluated at t_d so outputs align to t.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nxt_start[i] = sat_add(start_q[i], spc_act_d[i]);
      pulse_end[i] = sat_add(start_q[i], wid_act_d[i]);
      st_d[i]      = st_q[i];
      start_d[i]   = start_q[i];
      k_d[i]       = k_q[i];
      if (!run_d) begin
        st_d[i]    = ST_DONE;
        start_d[i] = '0;
        k_d[i]     = '0;
      end else if (start_period) begin
        start_d[i] = dly_act_d[i];
        k_d[i]     = '0;
        if (wid_act_d[i] == '0)      st_d[i] = ST_DONE;
        else if (dly_act_d[i] == '0) st_d[i] = ST_ON;
        else                         st_d[i] = ST_WAIT;
      end else begin
        case (st_q[i])
          ST_WAIT, ST_GAP: if (t_d == start_q[i]) st_d[i] = ST_ON;
          ST_ON: begin
            if ((k_q[i] < rep_act_d[i]) && (t_d == nxt_start[i])) begin
              k_d[i]     = k_q[i] + CW'(1);
              start_d[i] = nxt_start[i];
            end else if (t_d == pulse_end[i]) begin
              if ((k_q[i] < rep_act_d[i]) && (nxt_start[i] > pulse_end[i])) begin
                st_d[i]    = ST_GAP;
                k_d[i]     = k_q[i] + CW'(1);
                start_d[i] = nxt_start[i];
              end else begin
                st_d[i] = ST_DONE;
              end
            end
          end
          default: st_d[i] = st_q[i];
        endcase
      end
    end
  end

  always_comb begin
    any_active = 1'b0;
    ch_out_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (st_d[i] != ST_DONE) any_active = 1'b1;
      ch_out_d[i] = run_d && (st_d[i] == ST_ON);
    end
    sync_d  = run_d && (t_d < CW'(SYNC_W));
    pdone_d = run_d && (t_d == per_eff_d - CW'(1));
    busy_d  = run_d;
    // Blanking tail restarts while any channel is still sequencing and is dropped at every period start.
    if (!run_d) begin
      inhib_d = 1'b0;
      tail_d  = '0;
    end else if (any_active) begin
      inhib_d = 1'b1;
      tail_d  = blk_act_d;
    end else if (!start_period && (tail_q != '0)) begin
      inhib_d = 1'b1;
      tail_d  = tail_q - CW'(1);
    end else begin
      inhib_d = 1'b0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_sh_q  <= CW'(DEF_PERIOD);
      per_act_q <= CW'(DEF_PERIOD);
      blk_sh_q  <= CW'(DEF_BLOCK_OFF);
      blk_act_q <= CW'(DEF_BLOCK_OFF);
      for (int i = 0; i < NCH; i++) begin
        dly_sh_q[i]  <= CW'(DEF_DELAY);
        dly_act_q[i] <= CW'(DEF_DELAY);
        wid_sh_q[i]  <= (i == 0) ? CW'(DEF_WIDTH) : '0;
        wid_act_q[i] <= (i == 0) ? CW'(DEF_WIDTH) : '0;
        spc_sh_q[i]  <= CW'(DEF_SPACE);
        spc_act_q[i] <= CW'(DEF_SPACE);
        rep_sh_q[i]  <= CW'(DEF_REPS);
        rep_act_q[i] <= CW'(DEF_REPS);
        st_q[i]      <= ST_DONE;
        start_q[i]   <= '0;
        k_q[i]       <= '0;
      end
      en_q     <= (DEF_EN != 0);
      ss_q     <= 1'b0;
      run_q    <= 1'b0;
      t_q      <= '0;
      tail_q   <= '0;
      ch_out_q <= '0;
      sync_q   <= 1'b0;
      inhib_q  <= 1'b0;
      pdone_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      per_sh_q  <= per_sh_d;
      per_act_q <= per_act_d;
      blk_sh_q  <= blk_sh_d;
      blk_act_q <= blk_act_d;
      dly_sh_q  <= dly_sh_d;
      dly_act_q <= dly_act_d;
      wid_sh_q  <= wid_sh_d;
      wid_act_q <= wid_act_d;
      spc_sh_q  <= spc_sh_d;
      spc_act_q <= spc_act_d;
      rep_sh_q  <= rep_sh_d;
      rep_act_q <= rep_act_d;
      for (int i = 0; i < NCH; i++) begin
        st_q[i]    <= st_d[i];
        start_q[i] <= start_d[i];
        k_q[i]     <= k_d[i];
      end
      en_q     <= en_d;
      ss_q     <= ss_d;
      run_q    <= run_d;
      t_q      <= t_d;
      tail_q   <= tail_d;
      ch_out_q <= ch_out_d;
      sync_q   <= sync_d;
      inhib_q  <= inhib_d;
      pdone_q  <= pdone_d;
      busy_q   <= busy_d;
    end
  end

  assign ch_out      = ch_out_q;
  assign sync        = sync_q;
  assign inhib       = inhib_q;
  assign period_done = pdone_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Directed bench for pulse_seq_gen: each period is captured into bit vectors indexed by t
// and compared against hand-computed windows.
module tb_pulse_seq_gen;

  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int AW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           wrEn;
  logic [AW-1:0]  wrAddr;
  logic [CW-1:0]  wrData;
  logic [NCH-1:0] chOut;
  logic           sync, inhib, periodDone, busy;

  int vectorsApplied = 0;
  int miscompares    = 0;

  logic [127:0] capCh0, capCh1, capSync, capInhib, capDone, capBusy;

  pulse_seq_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .ch_out     (chOut),
    .sync       (sync),
    .inhib      (inhib),
    .period_done(periodDone),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] win(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  task automatic applyStimulus(input int addr, input int data);
    wrEn   = 1'b1;
    wrAddr = AW'(addr);
    wrData = CW'(data);
    tick();
    wrEn   = 1'b0;
  endtask

  // Records n cycles starting at the current t; optionally issues one register write in cycle wrT.
  task automatic capturePeriod(input int n, input int wrT, input int wa, input int wd);
    capCh0 = '0; capCh1 = '0; capSync = '0; capInhib = '0; capDone = '0; capBusy = '0;
    for (int t = 0; t < n; t++) begin
      capCh0[t]   = chOut[0];
      capCh1[t]   = chOut[1];
      capSync[t]  = sync;
      capInhib[t] = inhib;
      capDone[t]  = periodDone;
      capBusy[t]  = busy;
      if (t == wrT) begin
        wrEn   = 1'b1;
        wrAddr = AW'(wa);
        wrData = CW'(wd);
      end
      tick();
      wrEn = 1'b0;
    end
  endtask

  // Default timing: period 1000, ch0 pulses at 200 and 600 (w=30), inhib tail of 100 after t=630.
  task automatic checkDefaultPeriod(input string pfx);
    int firstDone, firstCh0, ch0Count, ch1Count, inhibCount, syncCount;
    firstDone = -1; firstCh0 = -1;
    ch0Count = 0; ch1Count = 0; inhibCount = 0; syncCount = 0;
    for (int t = 0; t < 1000; t++) begin
      if (periodDone && firstDone < 0) firstDone = t;
      if (chOut[0] && firstCh0 < 0) firstCh0 = t;
      if (chOut[0]) ch0Count++;
      if (chOut[1]) ch1Count++;
      if (inhib) inhibCount++;
      if (sync) syncCount++;
      tick();
    end
    checkOutput({pfx, "_done_t"},   128'(firstDone),  128'(999));
    checkOutput({pfx, "_ch0_first"}, 128'(firstCh0),  128'(200));
    checkOutput({pfx, "_ch0_count"}, 128'(ch0Count),  128'(60));
    checkOutput({pfx, "_ch1_count"}, 128'(ch1Count),  128'(0));
    checkOutput({pfx, "_inhib_cnt"}, 128'(inhibCount), 128'(730));
    checkOutput({pfx, "_sync_cnt"},  128'(syncCount),  128'(4));
  endtask

  initial begin
    reset  = 1'b1;
    wrEn   = 1'b0;
    wrAddr = '0;
    wrData = '0;
    tick();
    tick();
    checkOutput("reset_outputs", 128'({chOut, sync, inhib, periodDone, busy}), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("first_cycle", 128'({chOut, sync, inhib, busy}), 128'(5'b00111));
    checkDefaultPeriod("default");

    // Basic train with a w=0 channel and an 8-cycle blanking tail
    applyStimulus(2, 0);
    checkOutput("disable_outputs", 128'({chOut, sync, inhib, periodDone, busy}), 128'(0));
    applyStimulus(0, 100);
    applyStimulus(1, 8);
    applyStimulus(4, 10);
    applyStimulus(5, 5);
    applyStimulus(6, 20);
    applyStimulus(7, 2);
    applyStimulus(9, 0);
    applyStimulus(2, 1);
    capturePeriod(100, -1, 0, 0);
    checkOutput("p1_ch0",   capCh0,   win(10, 14) | win(30, 34) | win(50, 54));
    checkOutput("p1_ch1",   capCh1,   '0);
    checkOutput("p1_sync",  capSync,  win(0, 3));
    checkOutput("p1_done",  capDone,  win(99, 99));
    checkOutput("p1_inhib", capInhib, win(0, 62));
    checkOutput("p1_busy",  capBusy,  win(0, 99));
    capturePeriod(100, -1, 0, 0);
    checkOutput("p2_ch0",   capCh0,   win(10, 14) | win(30, 34) | win(50, 54));
    checkOutput("p2_inhib", capInhib, win(0, 62));

    // Shadowed width updates: mid-period write and a write in the wrap cycle
    capturePeriod(100, 40, 5, 7);
    checkOutput("midwr_cur_ch0", capCh0, win(10, 14) | win(30, 34) | win(50, 54));
    capturePeriod(100, 99, 5, 3);
    checkOutput("midwr_next_ch0", capCh0, win(10, 16) | win(30, 36) | win(50, 56));
    checkOutput("midwr_next_inhib", capInhib, win(0, 64));
    capturePeriod(100, -1, 0, 0);
    checkOutput("wrapwr_ch0", capCh0, win(10, 12) | win(30, 32) | win(50, 52));
    checkOutput("wrapwr_inhib", capInhib, win(0, 60));

    // Truncation at the period end
    applyStimulus(2, 0);
    applyStimulus(0, 60);
    applyStimulus(4, 50);
    applyStimulus(5, 20);
    applyStimulus(2, 1);
    capturePeriod(60, -1, 0, 0);
    checkOutput("trunc_ch0",   capCh0,   win(50, 59));
    checkOutput("trunc_done",  capDone,  win(59, 59));
    checkOutput("trunc_inhib", capInhib, win(0, 59));
    capturePeriod(60, -1, 0, 0);
    checkOutput("trunc_ch0_p2", capCh0, win(50, 59));

    // Period 1 is clamped to 2
    applyStimulus(2, 0);
    applyStimulus(0, 1);
    applyStimulus(4, 0);
    applyStimulus(5, 1);
    applyStimulus(7, 0);
    applyStimulus(2, 1);
    capturePeriod(4, -1, 0, 0);
    checkOutput("per1_ch0",  capCh0,  win(0, 0) | win(2, 2));
    checkOutput("per1_done", capDone, win(1, 1) | win(3, 3));

    // Single shot runs exactly one period
    applyStimulus(2, 0);
    applyStimulus(0, 20);
    applyStimulus(4, 2);
    applyStimulus(5, 3);
    applyStimulus(7, 0);
    applyStimulus(2, 3);
    capturePeriod(40, -1, 0, 0);
    checkOutput("ss_busy",  capBusy,  win(0, 19));
    checkOutput("ss_ch0",   capCh0,   win(2, 4));
    checkOutput("ss_done",  capDone,  win(19, 19));
    checkOutput("ss_inhib", capInhib, win(0, 12));
    checkOutput("ss_sync",  capSync,  win(0, 3));

    // Reset in the middle of a running period
    applyStimulus(0, 100);
    applyStimulus(2, 1);
    repeat (33) tick();
    reset = 1'b1;
    tick();
    checkOutput("reset_midrun", 128'({chOut, sync, inhib, periodDone, busy}), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("restart_cycle", 128'({chOut, sync, inhib, busy}), 128'(5'b00111));
    checkDefaultPeriod("after_reset");

    // Merged pulses (s<w) on ch0 and a zero-spacing train on ch1
    applyStimulus(2, 0);
    applyStimulus(0, 40);
    applyStimulus(1, 4);
    applyStimulus(4, 0);
    applyStimulus(5, 5);
    applyStimulus(6, 3);
    applyStimulus(7, 2);
    applyStimulus(8, 20);
    applyStimulus(9, 2);
    applyStimulus(10, 0);
    applyStimulus(11, 3);
    applyStimulus(2, 1);
    capturePeriod(40, -1, 0, 0);
    checkOutput("merge_ch0",   capCh0,   win(0, 10));
    checkOutput("merge_ch1",   capCh1,   win(20, 21));
    checkOutput("merge_inhib", capInhib, win(0, 25));
    checkOutput("merge_done",  capDone,  win(39, 39));

    // Disable while ch0 is high
    repeat (5) tick();
    checkOutput("ch_before_disable", 128'(chOut), 128'(2'b01));
    applyStimulus(2, 0);
    checkOutput("disable_midperiod", 128'({chOut, sync, inhib, periodDone, busy}), 128'(0));
    repeat (3) tick();
    checkOutput("held_disabled", 128'({chOut, sync, inhib, periodDone, busy}), 128'(0));

    // Saturating spacing: the second pulse start is unreachable so ch1 never reaches DONE
    applyStimulus(5, 0);
    applyStimulus(8, 10);
    applyStimulus(9, 2);
    applyStimulus(10, 65528);
    applyStimulus(11, 1);
    applyStimulus(2, 1);
    capturePeriod(40, -1, 0, 0);
    checkOutput("sat_ch0",   capCh0,   '0);
    checkOutput("sat_ch1",   capCh1,   win(10, 11));
    checkOutput("sat_inhib", capInhib, win(0, 39));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_seq_gen.md
Name: pulse_seq_gen

Overview:
Parametrised successor to the single-sequence pulse generator. Drives NCH independent pulse channels inside a common repetition period. Each channel has its own delay, width, spacing and repeat count, which together cover Hahn-echo and CPMG trains. Parameters are written at runtime through a register port fed by the UART command decoder, and the new values are applied glitch-free at period boundaries.

Parameters:
NCH, 4, number of pulse channels (1..8)
CW, 32, width of timing registers and counters, in clk cycles
SYNC_W, 4, sync pulse length in cycles
DEF_PERIOD, 1000, reset period
DEF_DELAY, 200, reset delay for every channel
DEF_WIDTH, 30, reset width for channel 0; other channels reset to 0
DEF_SPACE, 400, reset pulse spacing for every channel
DEF_REPS, 1, reset repeat count for every channel
DEF_BLOCK_OFF, 100, reset inhibit tail length
DEF_EN, 1, reset value of the enable bit
AW, derived: clog2(4+4*NCH), register address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  register write strobe, one cycle per write
wr_addr  in  AW  register address
wr_data  in  CW  register write data
ch_out  out  NCH  pulse outputs
sync  out  1  period-start marker
inhib  out  1  receiver blanking / protection output
period_done  out  1  one-cycle strobe in the last cycle of each period
busy  out  1  high while a period is running

Behaviour:
- Register map:
  - 0 period
  - 1 block_off
  - 2 control: bit0 enable, bit1 single_shot
  - 3 reserved, ignored
  - 4+4i+k for channel i: k=0 delay, k=1 width, k=2 spacing, k=3 reps
  - Writes to unmapped addresses are ignored.
- Shadowing:
  - period, block_off and the channel registers write into shadow registers.
  - Shadow values copy to the active registers on the cycle the period wraps, or on any cycle while disabled.
  - A write in the wrap cycle is included in that copy.
  - Control writes take effect on the next cycle.
- Reset:
  - All shadow and active registers take their defaults, enable=DEF_EN, single_shot=0, t=0.
  - All outputs are 0 in the cycle after reset.
  - Reset asserted mid-period aborts the period immediately.
- Period counter t:
  - Counts 0..period-1 while enabled, then wraps to 0.
  - A period value below 2 is treated as 2.
  - busy=enable.
  - period_done=1 when t=period-1.
- Enable / disable:
  - When disabled, t is held at 0 and all outputs are 0.
  - Enable rising: t=0 in the first enabled cycle.
  - Disable mid-period forces all outputs low on the next cycle.
- Single-shot: when single_shot=1, enable clears automatically at the wrap. Exactly one period runs.
- sync: 1 for t in [0, min(SYNC_W, period)).
- Channel outputs:
  - ch_out[i]=1 for t in [d+k*s, d+k*s+w) for k=0..r, using active d, w, s, r.
  - Outputs are registered and all aligned to the same t, so there is no skew between channels.
  - w=0: the channel never asserts.
  - s<=w: consecutive pulses merge into a continuous high.
  - Pulses that run past period-1 are truncated at the wrap and do not carry into the next period.
- Channel FSM, one per channel:
  - States: WAIT, ON, GAP, DONE.
  - Enters WAIT at t=0, or DONE directly if w=0.
  - Counters are CW wide. Arithmetic saturates at 2^CW-1 with no wrap, so a huge delay simply never fires.
- inhib:
  - 1 from t=0 while any channel with w>0 has not reached DONE.
  - Stays 1 for block_off further cycles after the last channel reaches DONE.
  - Clipped at the period end.
  - 0 for the whole period if every w=0.

Test Plan:
1. NCH=2, CW=16. Period 100, ch0 d=10 w=5 s=20 r=2, ch1 w=0 -> ch0 high t=10..14, 30..34, 50..54; ch1 stays 0; sync high t=0..3; period_done at t=99.
2. Same setup with block_off=8 -> inhib high t=0..62, low t=63..99; repeats identically in period 2.
3. Write ch0 width=7 at t=40 -> current period keeps w=5; next period pulses t=10..16, 30..36, 50..56. A write landing exactly at t=99 takes effect at the next t=0.
4. Period 60, ch0 d=50 w=20 -> ch0 high t=50..59 only, low at the new t=0. Period=1 behaves as period=2.
5. single_shot=1 with enable=1 -> exactly one period of outputs, then busy=0 and outputs 0. Reset pulsed at t=33 of a normal run -> outputs 0 the next cycle, registers back to defaults, t restarts at 0.
6. s=3 w=5 r=2 d=0 -> ch0 continuously high t=0..10.
